// File: rtl/lstm_sequencer.sv
// lstm_sequencer
//   Runs a single LSTM cell instance over a sequence of timesteps. Each input
//   sample becomes one cell step; the cell's y/C results are fed back as h/C
//   for the next step, and h0/C0 are loaded on the first step of a sequence.
//   Per-step outputs leave on a valid/ready stream. Steps never overlap,
//   because the next issue needs the previous step's hidden state.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   h0, C0                initial hidden/cell state, sampled on a first step
//   s_x, s_last, s_valid  input sample stream; s_ready = controller in IDLE
//   cell_ready            cell can take operands
//   cell_{x,h,C}_in       cell operands (held from internal registers)
//   cell_*_in_valid       operand strobes, one-cycle pulse per step
//   cell_y_out, cell_C_out, cell_y_out_valid   cell results
//   m_y, m_last, m_valid, m_ready              output stream
//   step_idx              steps completed in this sequence (saturating)
//   err                   sticky: [0] cell timeout, [1] result outside WAIT
module lstm_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] h0,
  input  logic [WIDTH-1:0] C0,
  input  logic [WIDTH-1:0] s_x,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             cell_ready,
  output logic [WIDTH-1:0] cell_x_in,
  output logic [WIDTH-1:0] cell_h_in,
  output logic [WIDTH-1:0] cell_C_in,
  output logic             cell_x_in_valid,
  output logic             cell_h_in_valid,
  output logic             cell_C_in_valid,
  input  logic [WIDTH-1:0] cell_y_out,
  input  logic [WIDTH-1:0] cell_C_out,
  input  logic             cell_y_out_valid,
  output logic [WIDTH-1:0] m_y,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] step_idx,
  output logic [1:0]       err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] h_reg;
  logic [WIDTH-1:0] c_reg;
  logic             last_reg;
  logic             first;
  logic [TW-1:0]    wait_cnt;
  logic             strobe;
  logic             timeout;

  // Timeout fires on the last of TIMEOUT WAIT cycles when no result showed up.
  always_comb begin
    timeout = (state == WAIT) && !cell_y_out_valid &&
              (wait_cnt == TW'(TIMEOUT - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (s_valid) state_next = ISSUE;
      ISSUE: if (cell_ready) state_next = WAIT;
      WAIT: begin
        if (cell_y_out_valid) state_next = HOLD;
        else if (timeout)     state_next = IDLE;
      end
      HOLD:  if (m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready         = (state == IDLE);
    strobe          = (state == ISSUE) && cell_ready;
    cell_x_in_valid = strobe;
    cell_h_in_valid = strobe;
    cell_C_in_valid = strobe;
    cell_x_in       = x_reg;
    cell_h_in       = h_reg;
    cell_C_in       = c_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_reg    <= '0;
      h_reg    <= '0;
      c_reg    <= '0;
      last_reg <= 1'b0;
      first    <= 1'b1;
      wait_cnt <= '0;
      m_y      <= '0;
      m_last   <= 1'b0;
      m_valid  <= 1'b0;
      step_idx <= '0;
      err      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (s_valid) begin
            x_reg    <= s_x;
            last_reg <= s_last;
            if (first) begin
              h_reg <= h0;
              c_reg <= C0;
              first <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (cell_ready) wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (cell_y_out_valid) begin
            h_reg   <= cell_y_out;
            c_reg   <= cell_C_out;
            m_y     <= cell_y_out;
            m_last  <= last_reg;
            m_valid <= 1'b1;
          end else if (timeout) begin
            // Abandon the sequence; the next sample restarts from h0/C0.
            err[0]   <= 1'b1;
            first    <= 1'b1;
            step_idx <= '0;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            // End of sequence clears the counter instead of incrementing it.
            if (m_last) begin
              first    <= 1'b1;
              step_idx <= '0;
            end else if (step_idx != '1) begin
              step_idx <= step_idx + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (cell_y_out_valid && (state != WAIT)) err[1] <= 1'b1;
    end
  end

endmodule
